// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one uart_tx serializer between
//               NREQ byte producers. Define UART_ARB_LOCK_EN to add the i_lock
//               port, which keeps multi-byte packets contiguous.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*WIDTH-1:0]    i_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NREQ-1:0]          i_lock,
`endif
    output logic [NREQ-1:0]          o_ack,
    output logic [WIDTH-1:0]         o_tx_data,
    output logic                     o_tx_wr,
    input  logic                     i_tx_busy,
    output logic [$clog2(NREQ)-1:0]  o_grant,
    output logic                     o_busy
);

    localparam int c_IDX_W = $clog2(NREQ);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NREQ - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_IDX_W-1:0]  r_last;
    logic [c_IDX_W-1:0]  r_grant;
    logic [WIDTH-1:0]    r_tx_data;
    logic                r_tx_wr;
    logic [NREQ-1:0]     r_ack;

    logic [c_IDX_W-1:0]  w_rr_winner;
    logic [c_IDX_W-1:0]  w_winner;
    logic                w_lock_hold;
    logic                w_take;
    logic                w_busy;
    int                  w_scan;

    // Scan from the farthest slot back to the nearest so the requester closest
    // after r_last is the one left standing.
    always_comb begin
        w_rr_winner = r_last;
        w_scan      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_scan = (int'(r_last) + k) % NREQ;
            if (i_req[w_scan]) begin
                w_rr_winner = c_IDX_W'(w_scan);
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    assign w_lock_hold = i_lock[r_last] & i_req[r_last];
`else
    assign w_lock_hold = 1'b0;
`endif

    assign w_winner = w_lock_hold ? r_last : w_rr_winner;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_WAIT_BUSY;
            end
            c_ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // uart_tx is not reset by this block, so a grant must also wait for it
    // to be idle, even straight out of reset.
    always_comb begin
        w_take = 1'b0;
        w_busy = 1'b1;
        if (r_state == c_ST_IDLE) begin
            w_busy = 1'b0;
            w_take = (|i_req) & ~i_tx_busy;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_wr   <= 1'b0;
            r_ack     <= '0;
            r_tx_data <= '0;
            r_grant   <= '0;
            r_last    <= c_LAST_RST;
        end else begin
            r_tx_wr <= w_take;
            r_ack   <= w_take ? (NREQ'(1) << w_winner) : '0;
            if (w_take) begin
                r_tx_data <= i_data[w_winner*WIDTH +: WIDTH];
                r_grant   <= w_winner;
                r_last    <= w_winner;
            end
        end
    end

    assign o_tx_wr   = r_tx_wr;
    assign o_ack     = r_ack;
    assign o_tx_data = r_tx_data;
    assign o_grant   = r_grant;
    assign o_busy    = w_busy;

endmodule
`default_nettype wire
